// File: rtl/ble_rx_ctrl.sv
// BLE receive sequencer: hops the advertising channels, frames CDR bits
// into bytes and reports packet completion or errors downstream.
//
// Ports:
//   clk, resetn            : clock, async active-low reset
//   start, stop            : scan enable (level), abort to IDLE (level)
//   cdr_en, cdr_channel    : controls driven to the CDR core
//   cdr_symbol(_clk)       : demodulated bit and its symbol clock
//   cdr_packet_detected    : access-address match from the CDR
//   byte_data, byte_valid  : received byte and its one-cycle strobe
//   pkt_done, pkt_err      : packet end / abort strobes
//   busy, state            : status (IDLE=0 SETTLE=1 SEARCH=2 RECV=3 HOP=4)

module ble_rx_ctrl #(
    parameter logic [5:0]  CH0           = 6'd37,
    parameter logic [5:0]  CH1           = 6'd38,
    parameter logic [5:0]  CH2           = 6'd39,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned DWELL_CYCLES  = 65535,
    parameter int unsigned SYM_TIMEOUT   = 64,
    parameter int unsigned MAX_LEN       = 37
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       stop,
    output logic       cdr_en,
    output logic [5:0] cdr_channel,
    input  logic       cdr_symbol,
    input  logic       cdr_symbol_clk,
    input  logic       cdr_packet_detected,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       pkt_done,
    output logic       pkt_err,
    output logic       busy,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_SEARCH = 3'd2,
        S_RECV   = 3'd3,
        S_HOP    = 3'd4
    } state_e;

    localparam logic [19:0] SETTLE_LAST = 20'(SETTLE_CYCLES);
    localparam logic [19:0] DWELL_LAST  = 20'(DWELL_CYCLES - 1);
    localparam logic [7:0]  SYM_TO      = 8'(SYM_TIMEOUT);
    localparam logic [7:0]  LEN_MAX     = 8'(MAX_LEN);

    state_e      state_q, state_d;
    logic [19:0] tmr_q, tmr_d;
    logic        sclk_prev_q, sclk_prev_d;
    logic [6:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [5:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  sym_tmr_q, sym_tmr_d;
    logic [1:0]  chan_idx_q, chan_idx_d;
    logic        cdr_en_q, cdr_en_d;
    logic [5:0]  cdr_channel_q, cdr_channel_d;
    logic [7:0]  byte_data_q, byte_data_d;
    logic        byte_valid_q, byte_valid_d;
    logic        pkt_done_q, pkt_done_d;
    logic        pkt_err_q, pkt_err_d;
    logic        busy_q, busy_d;

    logic        sym_edge;
    logic [7:0]  new_byte;
    logic [7:0]  sym_tmr_inc;

    function automatic logic [5:0] chan_code(input logic [1:0] idx);
        logic [5:0] c;
        unique case (idx)
            2'd0:    c = CH0;
            2'd1:    c = CH1;
            default: c = CH2;
        endcase
        return c;
    endfunction

    assign sym_edge    = cdr_symbol_clk & ~sclk_prev_q;
    // BLE sends LSB first: each new bit enters at the top and shifts down.
    assign new_byte    = {cdr_symbol, shift_q};
    assign sym_tmr_inc = sym_tmr_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        sclk_prev_d  = cdr_symbol_clk;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        len_d        = len_q;
        sym_tmr_d    = sym_tmr_q;
        chan_idx_d   = chan_idx_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = 1'b0;
        pkt_done_d   = 1'b0;
        pkt_err_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETTLE;
                    tmr_d   = '0;
                end
            end
            S_SETTLE: begin
                if (tmr_q == SETTLE_LAST) begin
                    state_d = S_SEARCH;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 20'd1;
                end
            end
            S_SEARCH: begin
                if (cdr_packet_detected) begin
                    state_d    = S_RECV;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    sym_tmr_d  = '0;
                end else if (tmr_q == DWELL_LAST) begin
                    state_d = S_HOP;
                end else begin
                    tmr_d = tmr_q + 20'd1;
                end
            end
            S_RECV: begin
                if (sym_edge) begin
                    sym_tmr_d = '0;
                    shift_d   = new_byte[7:1];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_data_d  = new_byte;
                        byte_valid_d = 1'b1;
                        byte_cnt_d   = byte_cnt_q + 6'd1;
                        if (byte_cnt_q == 6'd1) begin
                            len_d = new_byte;
                            if (new_byte > LEN_MAX) begin
                                pkt_err_d = 1'b1;
                                state_d   = S_HOP;
                            end
                        // Header(2) + payload(L) + CRC(3): last index L+4.
                        end else if (byte_cnt_q >= 6'd2 &&
                                     {2'b00, byte_cnt_q} == len_q + 8'd4) begin
                            pkt_done_d = 1'b1;
                            state_d    = S_HOP;
                        end
                    end
                end else begin
                    sym_tmr_d = sym_tmr_inc;
                    if (sym_tmr_inc == SYM_TO) begin
                        pkt_err_d = 1'b1;
                        state_d   = S_HOP;
                    end
                end
            end
            S_HOP: begin
                chan_idx_d = (chan_idx_q == 2'd2) ? 2'd0 : chan_idx_q + 2'd1;
                state_d    = start ? S_SETTLE : S_IDLE;
                tmr_d      = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything, and suppresses any strobe in flight.
        if (stop) begin
            state_d      = S_IDLE;
            chan_idx_d   = chan_idx_q;
            byte_data_d  = byte_data_q;
            byte_valid_d = 1'b0;
            pkt_done_d   = 1'b0;
            pkt_err_d    = 1'b0;
        end
    end

    // cdr_channel lags the index by a cycle so the channel change lands
    // inside SETTLE, leaving exactly SETTLE_CYCLES of cdr_en low after it.
    assign cdr_en_d      = (state_d == S_SEARCH) || (state_d == S_RECV);
    assign busy_d        = (state_d != S_IDLE);
    assign cdr_channel_d = chan_code(chan_idx_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            tmr_q         <= '0;
            sclk_prev_q   <= 1'b0;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            len_q         <= '0;
            sym_tmr_q     <= '0;
            chan_idx_q    <= '0;
            cdr_en_q      <= 1'b0;
            cdr_channel_q <= CH0;
            byte_data_q   <= '0;
            byte_valid_q  <= 1'b0;
            pkt_done_q    <= 1'b0;
            pkt_err_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            sclk_prev_q   <= sclk_prev_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            len_q         <= len_d;
            sym_tmr_q     <= sym_tmr_d;
            chan_idx_q    <= chan_idx_d;
            cdr_en_q      <= cdr_en_d;
            cdr_channel_q <= cdr_channel_d;
            byte_data_q   <= byte_data_d;
            byte_valid_q  <= byte_valid_d;
            pkt_done_q    <= pkt_done_d;
            pkt_err_q     <= pkt_err_d;
            busy_q        <= busy_d;
        end
    end

    assign cdr_en      = cdr_en_q;
    assign cdr_channel = cdr_channel_q;
    assign byte_data   = byte_data_q;
    assign byte_valid  = byte_valid_q;
    assign pkt_done    = pkt_done_q;
    assign pkt_err     = pkt_err_q;
    assign busy        = busy_q;
    assign state       = state_q;

endmodule

// File: tb/tb_ble_rx_ctrl.sv
// Directed-plus-random bench for ble_rx_ctrl: channel scan timing,
// packet framing, length overflow, symbol timeout, stop and async reset.

module tb_ble_rx_ctrl;

    localparam int S  = 64;
    localparam int D  = 200;
    localparam int TO = 64;
    localparam int ML = 37;

    logic       clk = 1'b0;
    logic       resetn, start, stop;
    logic       sym, symclk, det;
    logic       cdr_en, byte_valid, pkt_done, pkt_err, busy;
    logic [5:0] cdr_channel;
    logic [7:0] byte_data;
    logic [2:0] state;

    ble_rx_ctrl #(
        .SETTLE_CYCLES(S), .DWELL_CYCLES(D),
        .SYM_TIMEOUT(TO), .MAX_LEN(ML)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop),
        .cdr_en(cdr_en), .cdr_channel(cdr_channel),
        .cdr_symbol(sym), .cdr_symbol_clk(symclk),
        .cdr_packet_detected(det),
        .byte_data(byte_data), .byte_valid(byte_valid),
        .pkt_done(pkt_done), .pkt_err(pkt_err),
        .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic       dn;
        logic       er;
        int         t;
    } ev_t;

    ev_t        obsq[$];
    ev_t        expq[$];
    logic [7:0] pkt[$];
    int         checks = 0;
    int         errors = 0;
    int         last_edge;

    always @(negedge clk)
        if (byte_valid || pkt_done || pkt_err)
            obsq.push_back('{byte_data, byte_valid, pkt_done, pkt_err, cyc});

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic send_bit(input logic b, input int gap);
        sym    = b;
        symclk = 1'b1;
        tick();
        last_edge = cyc;
        symclk = 1'b0;
        ticks(gap);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i], $urandom_range(1, 4));
    endtask

    // Reference: every complete byte strobes; byte 1 is L; L>MAX_LEN errors
    // on that byte; otherwise byte L+4 (of 2+L+3) ends the packet.
    task automatic model_pkt();
        for (int i = 0; i < pkt.size(); i++) begin
            ev_t e;
            e.d  = pkt[i];
            e.v  = 1'b1;
            e.dn = 1'b0;
            e.er = 1'b0;
            e.t  = 0;
            if (i == 1 && int'(pkt[1]) > ML) e.er = 1'b1;
            else if (i >= 2 && i == int'(pkt[1]) + 4) e.dn = 1'b1;
            expq.push_back(e);
            if (e.er || e.dn) break;
        end
    endtask

    task automatic cmp(input string tag);
        int n;
        chk({tag, "_count"}, obsq.size(), expq.size());
        n = (obsq.size() < expq.size()) ? obsq.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_valid"}, obsq[i].v, expq[i].v);
            chk({tag, "_done"}, obsq[i].dn, expq[i].dn);
            chk({tag, "_err"}, obsq[i].er, expq[i].er);
            if (expq[i].v) chk({tag, "_data"}, obsq[i].d, expq[i].d);
        end
        obsq.delete();
        expq.delete();
        pkt.delete();
    endtask

    task automatic wait_search(input logic [5:0] ch);
        int n = 0;
        while (!(cdr_en && cdr_channel == ch) && n < 3000) begin
            tick();
            n++;
        end
        chk("wait_search_ch", cdr_channel, ch);
        chk("wait_search_en", cdr_en, 1);
    endtask

    task automatic detect();
        det = 1'b1;
        tick();
        det = 1'b0;
    endtask

    initial begin
        int         n, lowc, counting;
        int         chg_t[$], chg_ch[$], low[$];
        logic [5:0] prev;
        logic [15:0] w;
        int         exp_seq[3] = '{38, 39, 37};

        resetn = 1'b0; start = 1'b0; stop = 1'b0;
        sym = 1'b0; symclk = 1'b0; det = 1'b0;
        ticks(3);
        chk("rst_state", state, 0);
        chk("rst_en", cdr_en, 0);
        chk("rst_channel", cdr_channel, 37);
        chk("rst_busy", busy, 0);
        chk("rst_data", byte_data, 0);
        chk("rst_strobes", {byte_valid, pkt_done, pkt_err}, 0);
        @(negedge clk) resetn = 1'b1;
        ticks(2);
        obsq.delete();

        // Search entry latency: start seen at edge t, cdr_en at t+1+S.
        start = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!cdr_en && n < 500);
        chk("search_entry", n, S + 2);
        chk("search_busy", busy, 1);
        chk("search_state", state, 2);

        // Scan with no detection.
        prev = cdr_channel; counting = 0; lowc = 0; n = 0;
        while (low.size() < 3 && n < 1200) begin
            tick();
            n++;
            if (cdr_channel != prev) begin
                chg_t.push_back(cyc);
                chg_ch.push_back(int'(cdr_channel));
                prev = cdr_channel;
                counting = 1;
                lowc = 0;
            end
            if (counting != 0) begin
                if (!cdr_en) lowc++;
                else begin low.push_back(lowc); counting = 0; end
            end
        end
        chk("scan_changes", low.size(), 3);
        if (low.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("scan_channel", chg_ch[i], exp_seq[i]);
                chk("scan_en_low", low[i], S);
            end
            chk("scan_interval1", chg_t[1] - chg_t[0], S + D + 2);
            chk("scan_interval2", chg_t[2] - chg_t[1], S + D + 2);
        end
        chk("scan_no_strobes", obsq.size(), 0);
        obsq.delete();

        // Good packet on 38.
        wait_search(6'd38);
        detect();
        pkt.push_back(8'h40);
        pkt.push_back(8'h06);
        for (int i = 0; i < 9; i++) pkt.push_back(8'($urandom()));
        for (int i = 0; i < 11; i++) send_byte(pkt[i]);
        ticks(4);
        model_pkt();
        cmp("good");
        chk("good_next_ch", cdr_channel, 39);

        // Length overflow on 39.
        wait_search(6'd39);
        detect();
        pkt.push_back(8'($urandom()));
        pkt.push_back(8'h30);
        pkt.push_back(8'($urandom()));
        pkt.push_back(8'($urandom()));
        for (int i = 0; i < 4; i++) send_byte(pkt[i]);
        ticks(4);
        model_pkt();
        cmp("ovf");
        chk("ovf_next_ch", cdr_channel, 37);

        // Symbol timeout after 13 bits on 37.
        wait_search(6'd37);
        detect();
        w = 16'($urandom());
        for (int i = 0; i < 13; i++) send_bit(w[i], $urandom_range(1, 4));
        n = 0;
        while (!(obsq.size() > 0 && obsq[obsq.size()-1].er) && n < 200) begin
            tick();
            n++;
        end
        ticks(4);
        chk("to_seen", (obsq.size() > 0) ? obsq[obsq.size()-1].er : 1'b0, 1);
        if (obsq.size() > 0)
            chk("to_delay", obsq[obsq.size()-1].t - last_edge, TO);
        pkt.push_back(w[7:0]);
        model_pkt();
        expq.push_back('{8'h00, 1'b0, 1'b0, 1'b1, 0});
        cmp("timeout");
        chk("to_next_ch", cdr_channel, 38);

        // Stop together with start, on the 8th symbol edge.
        wait_search(6'd38);
        detect();
        w = 16'($urandom());
        for (int i = 0; i < 7; i++) send_bit(w[i], $urandom_range(1, 4));
        sym = w[7];
        symclk = 1'b1;
        stop = 1'b1;
        tick();
        symclk = 1'b0;
        chk("stop_state", state, 0);
        chk("stop_en", cdr_en, 0);
        chk("stop_busy", busy, 0);
        stop = 1'b0;
        ticks(3);
        cmp("stop");
        chk("resume_state", state, 1);
        chk("resume_ch", cdr_channel, 38);

        // Async reset mid-packet.
        wait_search(6'd38);
        detect();
        w = 16'($urandom());
        for (int i = 0; i < 10; i++) send_bit(w[i], $urandom_range(1, 4));
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_en", cdr_en, 0);
        chk("arst_channel", cdr_channel, 37);
        chk("arst_busy", busy, 0);
        chk("arst_data", byte_data, 0);
        chk("arst_strobes", {byte_valid, pkt_done, pkt_err}, 0);
        ticks(2);
        pkt.push_back(w[7:0]);
        model_pkt();
        cmp("arst");
        @(negedge clk) resetn = 1'b1;
        n = 0;
        while (!cdr_en && n < 500) begin tick(); n++; end
        chk("arst_resume_en", cdr_en, 1);
        chk("arst_resume_ch", cdr_channel, 37);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ble_rx_ctrl.md
# ble_rx_ctrl

Receive sequencer for the BLE RX chain: owns the `en` and `channel` controls of the `ble_cdr` core and consumes its `demod_symbol`, `demod_symbol_clk` and `packet_detected` outputs.

- Scans the three advertising channels with a per-channel dwell timeout.
- On detection, frames the demodulated bitstream into bytes and uses the PDU length field to find the packet end.
- Reports bytes, packet completion and errors to downstream logic, then hops to the next channel.

## Interface
- `CH0`, default 37: first channel in the hop list (6-bit channel code driven to the CDR).
- `CH1`, default 38: second hop channel.
- `CH2`, default 39: third hop channel.
- `SETTLE_CYCLES`, default 64: cycles `cdr_en` is held low after every channel change.
- `DWELL_CYCLES`, default 65535: cycles spent in SEARCH per channel before hopping (max 2^20-1).
- `SYM_TIMEOUT`, default 64: max cycles between symbol-clock edges in RECV before the packet is aborted.
- `MAX_LEN`, default 37: largest accepted PDU length field, in bytes.

Ports (clock and reset first):
- `clk` in 1: system clock; all logic on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: level; begins scanning from IDLE.
- `stop` in 1: level; returns to IDLE from any state.
- `cdr_en` out 1: enable to the CDR core.
- `cdr_channel` out 6: channel select to the CDR core.
- `cdr_symbol` in 1: demodulated bit from the CDR.
- `cdr_symbol_clk` in 1: symbol clock from the CDR; synchronous to `clk`.
- `cdr_packet_detected` in 1: access-address match from the CDR.
- `byte_data` out 8: assembled byte; valid only while `byte_valid` is high.
- `byte_valid` out 1: one-cycle strobe per received byte.
- `pkt_done` out 1: one-cycle strobe coincident with the final byte's `byte_valid`.
- `pkt_err` out 1: one-cycle strobe on symbol timeout or length overflow.
- `busy` out 1: high in every state except IDLE.
- `state` out 3: current state encoding (IDLE=0, SETTLE=1, SEARCH=2, RECV=3, HOP=4).

## Operation
- **Reset values:** state IDLE; `cdr_en`=0; `cdr_channel`=CH0; `byte_data`=0; all strobes 0; `busy`=0; every counter and the channel index cleared.
- **IDLE:** `cdr_en`=0. When `start`=1 and `stop`=0, go to SETTLE. The channel index is not reset, so scanning resumes on the current channel.
- **SETTLE:** `cdr_en`=0 while counting SETTLE_CYCLES, which flushes CDR state. Then go to SEARCH.
- **SEARCH:** `cdr_en`=1 and the dwell counter runs.
  - `cdr_packet_detected`=1 → go to RECV; clear the bit count, byte count and symbol timer.
  - Dwell reaches DWELL_CYCLES → go to HOP.
  - If detection and dwell expiry fall in the same cycle, detection wins.
- **RECV:** `cdr_en`=1.
  - Symbol edge = `cdr_symbol_clk`=1 while its registered previous value was 0.
  - On each edge, shift `cdr_symbol` in LSB-first (BLE bit order).
  - On the 8th edge, present the byte on `byte_data`, increment the byte count and clear the bit count.
  - Byte index 1 (second byte) is the length field L.
  - If L > MAX_LEN: pulse `pkt_err` in the same cycle as that byte's `byte_valid`, then go to HOP.
  - Otherwise the packet is 2+L+3 bytes (header, payload, CRC). The last byte pulses `pkt_done`, then go to HOP.
  - The symbol timer clears on every edge. Reaching SYM_TIMEOUT → pulse `pkt_err`, discard the partial byte, go to HOP.
- **HOP:** one cycle. Channel index advances CH0→CH1→CH2→CH0 and `cdr_channel` updates. Then go to SETTLE; if `start`=0, go to IDLE instead.
- **`stop`:** has priority over every transition, including a simultaneous `start`. The next state is IDLE, `cdr_en` drops, and no strobe is issued for a partially received packet.
- **Other inputs:** `start` is ignored outside IDLE. `cdr_packet_detected` is ignored outside SEARCH.

## Timing
- **Byte strobe:** an edge sampled at clock edge t produces `byte_valid`/`byte_data` registered for the cycle t..t+1, so a byte is visible one cycle after its 8th symbol edge.
- **Strobe width:** exactly one cycle, never back-to-back; bytes are at least 8 symbol edges apart.
- **Search entry:** `start` seen at edge t → `cdr_en` rises at edge t+1+SETTLE_CYCLES.
- **Hop interval:** without detection, a channel change occurs every SETTLE_CYCLES+DWELL_CYCLES+2 cycles.
- **Detection:** `cdr_packet_detected` at edge t → RECV from edge t+1. A symbol edge in that same cycle t is not captured.
- **Counter widths:** dwell 20 bits; symbol timer 8 bits; byte count 6 bits, which covers 2+MAX_LEN+3 ≤ 63.
- **Asynchronous reset mid-packet:** all outputs return to reset values immediately; no strobes are issued.

## Test plan
- **Scan without packet:** reset; `start`=1; no detection → `cdr_channel` sequence 37,38,39,37. Each change arrives SETTLE+DWELL+2 cycles after the previous one, and `cdr_en` is low for exactly 64 cycles after each change.
- **Good packet:** on channel 38, assert detect, then send header 0x40, L=0x06, 6 payload bytes and 3 CRC bytes LSB-first → 11 `byte_valid` strobes with matching `byte_data`. `pkt_done` is coincident with the 11th, and `cdr_channel`=39 after HOP.
- **Length overflow:** L=0x30 (48 > 37) → `pkt_err` coincident with byte 2's `byte_valid`; no `pkt_done`; next channel selected.
- **Symbol timeout:** stop toggling `cdr_symbol_clk` after 13 bits → `pkt_err` 64 cycles after the last edge; no partial byte strobe; HOP.
- **Stop mid-RECV, with `start` and `stop` high together:** → next cycle state=IDLE, `cdr_en`=0, `busy`=0; no strobes.
- **Async reset during RECV:** outputs go to reset values before the next clock edge; after release with `start` high, scanning resumes on CH0.
